// File: rtl/psum_wb_collector_if.sv
// Writeback bus between a PE group and the psum collector, plus the collector's
// output-buffer write port. master = PE-group/buffer side, slave = collector.
interface psum_wb_collector_if #(
  parameter int ADDR_W = 10
);
  logic               wb_en;
  logic signed [18:0] groupsum_in1;
  logic signed [18:0] groupsum_in2;
  logic               mem_wr_en;
  logic [ADDR_W-1:0]  mem_wr_addr;
  logic [15:0]        mem_wr_data;

  modport master (
    output wb_en, groupsum_in1, groupsum_in2,
    input  mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  wb_en, groupsum_in1, groupsum_in2,
    output mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/psum_wb_collector.sv
// Accumulates PE-group writeback beats per output pixel, requantises to int8 and
// writes a tile of outputs. Optional macro PSUM_RELU_EN clamps outputs to [0,127].
module psum_wb_collector #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 10,
  parameter int SHIFT  = 7
) (
  input  logic                clk,
  input  logic                rst,
  psum_wb_collector_if.slave  bus,
  input  logic [3:0]          layer_i,
  input  logic                start_i,
  input  logic [7:0]          acc_len_i,
  input  logic [ADDR_W-1:0]   out_count_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);

  localparam logic [3:0] LAYER1 = 4'd1;
  localparam logic [3:0] LAYER5 = 4'd5;
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(1) << (SHIFT-1);
  localparam logic signed [ACC_W:0] QMAX = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] QMIN = (ACC_W+1)'(-128);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t                   state_q;
  logic signed [ACC_W-1:0]  acc1_q, acc2_q;
  logic [7:0]               beat_cnt_q;
  logic [7:0]               len_q;
  logic [3:0]               layer_q;
  logic [ADDR_W-1:0]        cnt_q;
  logic [ADDR_W-1:0]        addr_q;
  logic                     wr_en_q;
  logic [15:0]              wr_data_q;
  logic                     busy_q, done_q, overrun_q;

  logic                     lane_ok, dual, beat_v, full, last;
  logic signed [ACC_W-1:0]  beat1, beat2, sum1_d, sum2_d;
  logic [8:0]               cnt_d;
  logic [15:0]              wr_data_d;

  // Round half up, then saturate to int8 (or to [0,127] with ReLU).
  function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W:0] xe;
    logic signed [ACC_W:0] r;
    logic [7:0]            q;
    xe = {x[ACC_W-1], x};
    r  = (xe + RND) >>> SHIFT;
    if (r > QMAX)      q = 8'h7F;
    else if (r < QMIN) q = 8'h80;
    else               q = r[7:0];
`ifdef PSUM_RELU_EN
    if (r < 0) q = 8'h00;
`endif
    return q;
  endfunction

  always_comb begin
    lane_ok = (layer_q == LAYER1) || (layer_q == LAYER5);
    dual    = (layer_q == LAYER5);
    beat_v  = bus.wb_en && lane_ok;
    beat1   = {{(ACC_W-19){bus.groupsum_in1[18]}}, bus.groupsum_in1};
    beat2   = dual ? {{(ACC_W-19){bus.groupsum_in2[18]}}, bus.groupsum_in2} : '0;
    // A beat taken in the WRITE cycle starts the next output from zero.
    if (state_q == ST_WRITE) begin
      sum1_d = beat1;
      sum2_d = beat2;
      cnt_d  = 9'd1;
    end else begin
      sum1_d = acc1_q + beat1;
      sum2_d = acc2_q + beat2;
      cnt_d  = {1'b0, beat_cnt_q} + 9'd1;
    end
    full      = (cnt_d == {1'b0, len_q});
    last      = (addr_q == cnt_q - ADDR_W'(1));
    wr_data_d = {dual ? requant(sum2_d) : 8'h00, requant(sum1_d)};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      acc1_q     <= '0;
      acc2_q     <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      layer_q    <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            layer_q    <= layer_i;
            len_q      <= (acc_len_i == 8'd0) ? 8'd1 : acc_len_i;
            cnt_q      <= out_count_i;
            acc1_q     <= '0;
            acc2_q     <= '0;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            overrun_q  <= 1'b0;
            if (out_count_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ACCUM;
              busy_q  <= 1'b1;
            end
          end else if (bus.wb_en) begin
            overrun_q <= 1'b1;
          end
        end

        ST_ACCUM: begin
          if (beat_v) begin
            acc1_q     <= sum1_d;
            acc2_q     <= sum2_d;
            beat_cnt_q <= cnt_d[7:0];
            if (full) begin
              state_q   <= ST_WRITE;
              wr_en_q   <= 1'b1;
              wr_data_q <= wr_data_d;
            end
          end
        end

        ST_WRITE: begin
          if (!last) addr_q <= addr_q + ADDR_W'(1);
          if (beat_v) begin
            acc1_q     <= sum1_d;
            acc2_q     <= sum2_d;
            beat_cnt_q <= 8'd1;
          end else begin
            acc1_q     <= '0;
            acc2_q     <= '0;
            beat_cnt_q <= '0;
          end
          if (last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (beat_v && full) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= wr_data_d;
          end else begin
            state_q <= ST_ACCUM;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          if (bus.wb_en) overrun_q <= 1'b1;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_psum_wb_collector.sv
// Directed bench for psum_wb_collector: writes and done pulses are logged by a
// monitor and compared against hand-computed values.
module tb_psum_wb_collector;

  logic        clk;
  logic        rst;
  logic [3:0]  layer_i;
  logic        start_i;
  logic [7:0]  acc_len_i;
  logic [9:0]  out_count_i;
  logic        busy_o, done_o, overrun_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_n = 0;
  int done_c = 0;
  logic [9:0]  wa[$];
  logic [15:0] wd[$];
  int          wc[$];

  psum_wb_collector_if #(.ADDR_W(10)) bus ();

  psum_wb_collector #(.ACC_W(24), .ADDR_W(10), .SHIFT(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .layer_i     (layer_i),
    .start_i     (start_i),
    .acc_len_i   (acc_len_i),
    .out_count_i (out_count_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .overrun_o   (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.mem_wr_en === 1'b1) begin
      wa.push_back(bus.mem_wr_addr);
      wd.push_back(bus.mem_wr_data);
      wc.push_back(cyc);
    end
    if (done_o === 1'b1) begin
      done_n++;
      done_c = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic wb, input logic signed [18:0] g1,
                       input logic signed [18:0] g2);
    @(negedge clk);
    start_i          = st;
    bus.wb_en        = wb;
    bus.groupsum_in1 = g1;
    bus.groupsum_in2 = g2;
  endtask

  task automatic settle(input int n);
    repeat (n) drive(1'b0, 1'b0, 19'sd0, 19'sd0);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    done_n = 0;
  endtask

  task automatic begin_tile(input logic [3:0] l, input logic [7:0] len, input logic [9:0] cnt);
    layer_i     = l;
    acc_len_i   = len;
    out_count_i = cnt;
    drive(1'b1, 1'b0, 19'sd0, 19'sd0);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_n < target && n < 40) begin
      drive(1'b0, 1'b0, 19'sd0, 19'sd0);
      n++;
    end
    chk("done_seen", 32'(done_n >= target), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    layer_i = 4'd0;
    start_i = 1'b0;
    acc_len_i = 8'd0;
    out_count_i = 10'd0;
    bus.wb_en = 1'b0;
    bus.groupsum_in1 = '0;
    bus.groupsum_in2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_ovr", 32'(overrun_o), 32'd0);
    chk("rst_wren", 32'(bus.mem_wr_en), 32'd0);
    chk("rst_addr", 32'(bus.mem_wr_addr), 32'd0);
    chk("rst_data", 32'(bus.mem_wr_data), 32'd0);
    rst = 1'b1;
    settle(1);

    // Layer1, 3 beats summing to 256 -> 0x0002
    clear_log();
    begin_tile(4'd1, 8'd3, 10'd1);
    drive(1'b0, 1'b1, 19'sd100, 19'sd0);
    chk("t1_busy", 32'(busy_o), 32'd1);
    drive(1'b0, 1'b1, 19'sd200, 19'sd0);
    drive(1'b0, 1'b1, -19'sd44, 19'sd0);
    wait_done(1);
    settle(2);
    chk("t1_nwr", 32'(wc.size()), 32'd1);
    chk("t1_addr", 32'(wa[0]), 32'd0);
    chk("t1_data", 32'(wd[0]), 32'h0002);
    chk("t1_done_lat", 32'(done_c - wc[0]), 32'd1);
    chk("t1_done_n", 32'(done_n), 32'd1);
    chk("t1_ovr", 32'(overrun_o), 32'd0);
    chk("t1_idle_busy", 32'(busy_o), 32'd0);

    // Layer5, lane1 saturates high, lane2 rounds to -2
    clear_log();
    begin_tile(4'd5, 8'd2, 10'd1);
    drive(1'b0, 1'b1, 19'sd20000, -19'sd300);
    drive(1'b0, 1'b1, 19'sd20000, 19'sd0);
    wait_done(1);
    settle(1);
    chk("t2_nwr", 32'(wc.size()), 32'd1);
`ifdef PSUM_RELU_EN
    chk("t2_data", 32'(wd[0]), 32'h007F);
`else
    chk("t2_data", 32'(wd[0]), 32'hFE7F);
`endif

    // wb_en held through the WRITE cycle: no beat lost
    clear_log();
    begin_tile(4'd1, 8'd3, 10'd2);
    repeat (6) drive(1'b0, 1'b1, 19'sd128, 19'sd0);
    wait_done(1);
    settle(1);
    chk("t3_nwr", 32'(wc.size()), 32'd2);
    chk("t3_addr0", 32'(wa[0]), 32'd0);
    chk("t3_addr1", 32'(wa[1]), 32'd1);
    chk("t3_data0", 32'(wd[0]), 32'h0003);
    chk("t3_data1", 32'(wd[1]), 32'h0003);
    chk("t3_gap", 32'(wc[1] - wc[0]), 32'd3);
    chk("t3_done_lat", 32'(done_c - wc[1]), 32'd1);

    // acc_len 0 behaves as 1: back-to-back writes
    clear_log();
    begin_tile(4'd1, 8'd0, 10'd3);
    drive(1'b0, 1'b1, 19'sd128, 19'sd0);
    drive(1'b0, 1'b1, 19'sd256, 19'sd0);
    drive(1'b0, 1'b1, -19'sd128, 19'sd0);
    wait_done(1);
    settle(1);
    chk("t4_nwr", 32'(wc.size()), 32'd3);
    chk("t4_data0", 32'(wd[0]), 32'h0001);
    chk("t4_data1", 32'(wd[1]), 32'h0002);
    chk("t4_data2", 32'(wd[2]), 32'h00FF);
    chk("t4_addr2", 32'(wa[2]), 32'd2);
    chk("t4_consec", 32'(wc[2] - wc[0]), 32'd2);
    chk("t4_done_lat", 32'(done_c - wc[2]), 32'd1);

    // Reset mid-ACCUM, then a clean tile with no stale sum
    clear_log();
    begin_tile(4'd1, 8'd3, 10'd1);
    drive(1'b0, 1'b1, 19'sd128, 19'sd0);
    drive(1'b0, 1'b1, 19'sd128, 19'sd0);
    @(negedge clk);
    rst = 1'b0;
    bus.wb_en = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_wren", 32'(bus.mem_wr_en), 32'd0);
    chk("t5_data", 32'(bus.mem_wr_data), 32'd0);
    rst = 1'b1;
    begin_tile(4'd1, 8'd3, 10'd1);
    repeat (3) drive(1'b0, 1'b1, 19'sd128, 19'sd0);
    wait_done(1);
    settle(1);
    chk("t5_nwr", 32'(wc.size()), 32'd1);
    chk("t5_addr", 32'(wa[0]), 32'd0);
    chk("t5_wdata", 32'(wd[0]), 32'h0003);

    // wb_en while IDLE sets sticky overrun; start clears it (out_count 0 -> DONE)
    clear_log();
    drive(1'b0, 1'b1, 19'sd5, 19'sd5);
    drive(1'b0, 1'b0, 19'sd0, 19'sd0);
    chk("t6_ovr_set", 32'(overrun_o), 32'd1);
    settle(3);
    chk("t6_ovr_hold", 32'(overrun_o), 32'd1);
    begin_tile(4'd1, 8'd1, 10'd0);
    drive(1'b0, 1'b0, 19'sd0, 19'sd0);
    chk("t6_ovr_clr", 32'(overrun_o), 32'd0);
    wait_done(1);
    settle(1);
    chk("t6_nwr", 32'(wc.size()), 32'd0);

    // Unsupported layer code: beats discarded without overrun
    clear_log();
    begin_tile(4'd3, 8'd1, 10'd1);
    repeat (3) drive(1'b0, 1'b1, 19'sd128, 19'sd0);
    settle(2);
    chk("t7_nwr", 32'(wc.size()), 32'd0);
    chk("t7_ovr", 32'(overrun_o), 32'd0);
    chk("t7_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    settle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_wb_collector.md
Name: psum_wb_collector

Overview:
Downstream end of the PE-group writeback interface. Samples the signed group sums each time wb_en is high and accumulates a configurable number of beats per output pixel. Each completed sum is requantised to int8 and written to the output feature-map buffer. The block sequences a whole tile of outputs and reports completion to the layer controller.

Parameters:
ACC_W, 24, accumulator width per lane (signed)
ADDR_W, 10, output buffer address width
SHIFT, 7, requantisation right-shift amount (≥1)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low (`RstEnable` = 0)
layer  in  4  layer code: `Layer1` = lane-1 only; `Layer5` = both lanes; other codes = beats ignored
start  in  1  one-cycle pulse, begins a tile
acc_len  in  8  beats per output (0 treated as 1)
out_count  in  ADDR_W  outputs per tile
wb_en  in  1  group-sum valid strobe
groupsum_in1  in  19  signed lane-1 group sum
groupsum_in2  in  19  signed lane-2 group sum
mem_wr_en  out  1  output buffer write strobe
mem_wr_addr  out  ADDR_W  output buffer address
mem_wr_data  out  16  {lane2 int8, lane1 int8}
busy  out  1  high from ACCUM through WRITE
done  out  1  one-cycle tile-complete pulse
overrun  out  1  sticky: wb_en seen while IDLE/DONE; cleared by start

Behaviour:
- Reset (rst=0 at clk edge, any state, also mid-tile): state=IDLE; accumulators, beat_cnt, mem_wr_addr cleared; mem_wr_en, mem_wr_data, busy, done, overrun = 0.
- States: IDLE, ACCUM, WRITE, DONE.
- layer, acc_len and out_count are latched on start; they are not re-sampled mid-tile.
- IDLE: on start, clear accumulators, beat_cnt=0, addr=0, overrun=0, then go to ACCUM. If out_count==0, go directly to DONE instead.
- ACCUM: on wb_en, acc1 += sext(groupsum_in1). acc2 += sext(groupsum_in2) under `Layer5` only; acc2 stays 0 otherwise. Increment beat_cnt. The beat that makes beat_cnt reach acc_len moves the FSM to WRITE.
- WRITE (exactly 1 cycle): mem_wr_en=1 and mem_wr_data = {q(acc2), q(acc1)} at mem_wr_addr. The write occurs in the cycle after the final beat is sampled.
  - Then addr++. If the written addr == out_count-1, go to DONE; otherwise go to ACCUM.
  - A wb_en arriving in the WRITE cycle is not dropped: accumulators load that beat (not 0) and beat_cnt=1.
  - If acc_len==1 and another output remains, stay in WRITE for the next write.
  - Otherwise, with no wb_en, accumulators clear and beat_cnt=0.
- q(x): compute (x + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round half up), then clamp to [-128, 127]. The lane-2 byte is 0x00 unless `Layer5`.
- Accumulation wraps at ACC_W. No saturation is applied before q.
- DONE: done=1 for one cycle, busy=0, then return to IDLE. mem_wr_addr holds its last value until the next start.
- wb_en in IDLE or DONE is discarded and sets overrun.
- start while busy is ignored.
- wb_en under a layer code other than `Layer1`/`Layer5` is discarded (no count, no overrun).

Optional Feature:
RELU_EN_EN is not used. The macro is PSUM_RELU_EN.
- Defined: q(x) output is forced to 0 when the shifted value is negative, so the clamp range becomes [0, 127].
- Undefined: signed clamp to [-128, 127] as above.

Test Plan:
- `Layer1`, acc_len=3, out_count=1, beats 100, 200, -44 (sum 256) → 1 write: addr 0, data 0x0002. done asserts one cycle after the write. overrun=0.
- `Layer5`, acc_len=2, out_count=1, lane1 beats 20000, 20000; lane2 beats -300, 0 → lane1 = 127 (saturated) and lane2 = 0xFE (-236>>>7 = -2). data = 0xFE7F. With PSUM_RELU_EN: data = 0x007F.
- wb_en held high for 6 cycles, acc_len=3, out_count=2, every beat 128 → writes at addr 0 and 1, each data 0x0003. The beat in the WRITE cycle counts toward output 1, no beat is lost, and done follows the second write.
- acc_len=0 (treated as 1), out_count=3, back-to-back beats 128, 256, -128 → three consecutive write cycles with data 0x0001, 0x0002, 0x00FF.
- rst pulled low mid-ACCUM after 2 of 3 beats → next cycle all outputs are 0 and state is IDLE. A following start plus 3 beats of 128 writes 0x0003 at addr 0 (no stale sum).
- wb_en pulse while IDLE → overrun=1 and no write. overrun stays set until the next start clears it.
